// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register for the RV32I core.
//   Takes one instruction per cycle from the data-RAM access stage and holds it
//   for the register-file write port. The stage extracts load data (byte/half,
//   sign or zero extended) before the register, then selects the writeback
//   value. It flags misaligned loads and reserved load encodings, and qualifies
//   the regfile write enable. It also exposes a forwarding port and counts
//   retired instructions.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_valid / mem_ready     MEM-side handshake (mem_ready = !wb_stall)
//   flush                     kill the instruction offered this cycle
//   wb_stall                  hold all WB state
//   *_mem inputs              control, address and data from the MEM stage
//   *_wb outputs              registered WB state and qualified write enable
//   fwd_en/fwd_addr/fwd_data  forwarding copy of the WB write
//   retired_cnt               instructions that have left WB (wraps)
module mem_wb_stage #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned REGADDR_WIDTH = 5,
   parameter int unsigned OFF_WIDTH     = 2,
   parameter int unsigned CNT_WIDTH     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic                     flush,
   input  logic                     wb_stall,
   input  logic                     regs_write_mem,
   input  logic                     mem_to_reg_mem,
   input  logic [2:0]               funct3_mem,
   input  logic [OFF_WIDTH-1:0]     byte_off_mem,
   input  logic [DATA_WIDTH-1:0]    alu_result_mem,
   input  logic [DATA_WIDTH-1:0]    ram_out_mem,
   input  logic [REGADDR_WIDTH-1:0] rs1_addr_mem,
   input  logic [REGADDR_WIDTH-1:0] rs2_addr_mem,
   input  logic [REGADDR_WIDTH-1:0] rd_addr_mem,
   output logic                     wb_valid,
   output logic                     regs_write_wb,
   output logic [REGADDR_WIDTH-1:0] rd_addr_wb,
   output logic [DATA_WIDTH-1:0]    rd_wdata_wb,
   output logic [DATA_WIDTH-1:0]    alu_result_wb,
   output logic [DATA_WIDTH-1:0]    ram_out_wb,
   output logic [REGADDR_WIDTH-1:0] rs1_addr_wb,
   output logic [REGADDR_WIDTH-1:0] rs2_addr_wb,
   output logic                     misaligned_wb,
   output logic                     illegal_ld_wb,
   output logic                     fwd_en,
   output logic [REGADDR_WIDTH-1:0] fwd_addr,
   output logic [DATA_WIDTH-1:0]    fwd_data,
   output logic [CNT_WIDTH-1:0]     retired_cnt
);

   localparam int unsigned SEL_WIDTH = OFF_WIDTH + 3;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // WB register payload
   typedef struct packed {
      logic                     valid;
      logic                     regs_write;
      logic                     misaligned;
      logic                     illegal_ld;
      logic [REGADDR_WIDTH-1:0] rd_addr;
      logic [REGADDR_WIDTH-1:0] rs1_addr;
      logic [REGADDR_WIDTH-1:0] rs2_addr;
      logic [DATA_WIDTH-1:0]    rd_wdata;
      logic [DATA_WIDTH-1:0]    alu_result;
      logic [DATA_WIDTH-1:0]    ram_out;
   } wb_regs_t;

   wb_regs_t                wb_d, wb_q;
   logic [CNT_WIDTH-1:0]    cnt_d, cnt_q;

   logic [OFF_WIDTH-1:0]    half_off;
   logic [SEL_WIDTH-1:0]    byte_base;
   logic [SEL_WIDTH-1:0]    half_base;
   logic [7:0]              byte_lane;
   logic [15:0]             half_lane;
   logic [DATA_WIDTH-1:0]   ld_data;
   logic                    ld_misaligned;
   logic                    ld_illegal;
   logic                    next_valid;

   assign mem_ready = !wb_stall;

   // Lane selection: halfword ignores offset bit 0
   always_comb begin
      half_off  = byte_off_mem & ~OFF_WIDTH'(1);
      byte_base = {byte_off_mem, 3'b000};
      half_base = {half_off, 3'b000};
      byte_lane = ram_out_mem[byte_base +: 8];
      half_lane = ram_out_mem[half_base +: 16];
   end

   // Load extraction and fault classification
   always_comb begin
      ld_data       = ram_out_mem;
      ld_misaligned = 1'b0;
      ld_illegal    = 1'b0;
      unique case (funct3_mem)
         F3_LB:  ld_data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
         F3_LBU: ld_data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
         F3_LH: begin
            ld_data       = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            ld_misaligned = byte_off_mem[0];
         end
         F3_LHU: begin
            ld_data       = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            ld_misaligned = byte_off_mem[0];
         end
         F3_LW:  ld_misaligned = (byte_off_mem != '0);
         default: ld_illegal = 1'b1;
      endcase
      if (!mem_to_reg_mem) begin
         ld_misaligned = 1'b0;
         ld_illegal    = 1'b0;
      end
   end

   // Next WB state; fault flags and write enable are pre-qualified by valid
   always_comb begin
      wb_d       = wb_q;
      cnt_d      = cnt_q;
      next_valid = mem_valid & !flush;
      if (!wb_stall) begin
         wb_d.valid      = next_valid;
         wb_d.misaligned = next_valid & ld_misaligned;
         wb_d.illegal_ld = next_valid & ld_illegal;
         wb_d.regs_write = next_valid & regs_write_mem & (rd_addr_mem != '0)
                           & !ld_misaligned & !ld_illegal;
         wb_d.rd_addr    = rd_addr_mem;
         wb_d.rs1_addr   = rs1_addr_mem;
         wb_d.rs2_addr   = rs2_addr_mem;
         wb_d.rd_wdata   = mem_to_reg_mem ? ld_data : alu_result_mem;
         wb_d.alu_result = alu_result_mem;
         wb_d.ram_out    = ram_out_mem;
         if (wb_q.valid) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

   assign wb_valid      = wb_q.valid;
   assign regs_write_wb = wb_q.regs_write;
   assign rd_addr_wb    = wb_q.rd_addr;
   assign rd_wdata_wb   = wb_q.rd_wdata;
   assign alu_result_wb = wb_q.alu_result;
   assign ram_out_wb    = wb_q.ram_out;
   assign rs1_addr_wb   = wb_q.rs1_addr;
   assign rs2_addr_wb   = wb_q.rs2_addr;
   assign misaligned_wb = wb_q.misaligned;
   assign illegal_ld_wb = wb_q.illegal_ld;
   assign fwd_en        = wb_q.regs_write;
   assign fwd_addr      = wb_q.rd_addr;
   assign fwd_data      = wb_q.rd_wdata;
   assign retired_cnt   = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, load extraction, stall/flush,
// fault flags, x0 writes and counter wrap (second instance, 4-bit counter).
module tb_mem_wb_stage;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned OW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_valid, flush, wb_stall;
   logic          regs_write_mem, mem_to_reg_mem;
   logic [2:0]    funct3_mem;
   logic [OW-1:0] byte_off_mem;
   logic [DW-1:0] alu_result_mem, ram_out_mem;
   logic [AW-1:0] rs1_addr_mem, rs2_addr_mem, rd_addr_mem;

   logic          mem_ready, wb_valid, regs_write_wb, misaligned_wb, illegal_ld_wb, fwd_en;
   logic [AW-1:0] rd_addr_wb, rs1_addr_wb, rs2_addr_wb, fwd_addr;
   logic [DW-1:0] rd_wdata_wb, alu_result_wb, ram_out_wb, fwd_data;
   logic [31:0]   retired_cnt;

   logic          mem_ready4, wb_valid4, regs_write_wb4, misaligned_wb4, illegal_ld_wb4, fwd_en4;
   logic [AW-1:0] rd_addr_wb4, rs1_addr_wb4, rs2_addr_wb4, fwd_addr4;
   logic [DW-1:0] rd_wdata_wb4, alu_result_wb4, ram_out_wb4, fwd_data4;
   logic [3:0]    retired_cnt4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .flush(flush), .wb_stall(wb_stall), .regs_write_mem(regs_write_mem),
      .mem_to_reg_mem(mem_to_reg_mem), .funct3_mem(funct3_mem),
      .byte_off_mem(byte_off_mem), .alu_result_mem(alu_result_mem),
      .ram_out_mem(ram_out_mem), .rs1_addr_mem(rs1_addr_mem),
      .rs2_addr_mem(rs2_addr_mem), .rd_addr_mem(rd_addr_mem),
      .wb_valid(wb_valid), .regs_write_wb(regs_write_wb), .rd_addr_wb(rd_addr_wb),
      .rd_wdata_wb(rd_wdata_wb), .alu_result_wb(alu_result_wb), .ram_out_wb(ram_out_wb),
      .rs1_addr_wb(rs1_addr_wb), .rs2_addr_wb(rs2_addr_wb),
      .misaligned_wb(misaligned_wb), .illegal_ld_wb(illegal_ld_wb),
      .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .retired_cnt(retired_cnt)
   );

   mem_wb_stage #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready4),
      .flush(flush), .wb_stall(wb_stall), .regs_write_mem(regs_write_mem),
      .mem_to_reg_mem(mem_to_reg_mem), .funct3_mem(funct3_mem),
      .byte_off_mem(byte_off_mem), .alu_result_mem(alu_result_mem),
      .ram_out_mem(ram_out_mem), .rs1_addr_mem(rs1_addr_mem),
      .rs2_addr_mem(rs2_addr_mem), .rd_addr_mem(rd_addr_mem),
      .wb_valid(wb_valid4), .regs_write_wb(regs_write_wb4), .rd_addr_wb(rd_addr_wb4),
      .rd_wdata_wb(rd_wdata_wb4), .alu_result_wb(alu_result_wb4), .ram_out_wb(ram_out_wb4),
      .rs1_addr_wb(rs1_addr_wb4), .rs2_addr_wb(rs2_addr_wb4),
      .misaligned_wb(misaligned_wb4), .illegal_ld_wb(illegal_ld_wb4),
      .fwd_en(fwd_en4), .fwd_addr(fwd_addr4), .fwd_data(fwd_data4),
      .retired_cnt(retired_cnt4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; mem_valid = 1'b1; flush = 1'b0; wb_stall = 1'b0;
      regs_write_mem = 1'b1; mem_to_reg_mem = 1'b0; funct3_mem = 3'b010;
      byte_off_mem = 2'd0; alu_result_mem = 32'h1111_1111; ram_out_mem = 32'h2222_2222;
      rs1_addr_mem = 5'd1; rs2_addr_mem = 5'd2; rd_addr_mem = 5'd4;

      // Reset: two cycles with mem_valid high
      tick(); tick();
      chk("rst_valid", 64'(wb_valid), 64'd0);
      chk("rst_we", 64'(regs_write_wb), 64'd0);
      chk("rst_wdata", 64'(rd_wdata_wb), 64'd0);
      chk("rst_alu", 64'(alu_result_wb), 64'd0);
      chk("rst_cnt", 64'(retired_cnt), 64'd0);
      chk("rst_ready", 64'(mem_ready), 64'd1);
      rst = 1'b0;
      #1;
      chk("rst_release_valid", 64'(wb_valid), 64'd0);

      // Loads from 0x80FF7F01
      mem_to_reg_mem = 1'b1; ram_out_mem = 32'h80FF_7F01; rd_addr_mem = 5'd7;
      funct3_mem = 3'b000; byte_off_mem = 2'd3;
      tick();
      chk("lb", 64'(rd_wdata_wb), 64'hFFFF_FF80);
      chk("lb_valid", 64'(wb_valid), 64'd1);
      chk("lb_we", 64'(regs_write_wb), 64'd1);
      chk("lb_fwd_addr", 64'(fwd_addr), 64'd7);
      chk("lb_cnt", 64'(retired_cnt), 64'd0);
      funct3_mem = 3'b100;
      tick();
      chk("lbu", 64'(rd_wdata_wb), 64'h0000_0080);
      chk("lbu_cnt", 64'(retired_cnt), 64'd1);
      funct3_mem = 3'b001; byte_off_mem = 2'd2;
      tick();
      chk("lh", 64'(rd_wdata_wb), 64'hFFFF_80FF);
      chk("lh_fwd_data", 64'(fwd_data), 64'hFFFF_80FF);
      funct3_mem = 3'b101;
      tick();
      chk("lhu", 64'(rd_wdata_wb), 64'h0000_80FF);
      chk("lhu_ram", 64'(ram_out_wb), 64'h80FF_7F01);
      chk("lhu_cnt", 64'(retired_cnt), 64'd3);

      // Instruction A, then stall with B offered
      mem_to_reg_mem = 1'b0; funct3_mem = 3'b010; byte_off_mem = 2'd0;
      rd_addr_mem = 5'd5; alu_result_mem = 32'h0000_1234; rs1_addr_mem = 5'd10;
      tick();
      chk("a_wdata", 64'(rd_wdata_wb), 64'h1234);
      chk("a_rs1", 64'(rs1_addr_wb), 64'd10);
      chk("a_cnt", 64'(retired_cnt), 64'd4);
      wb_stall = 1'b1; rd_addr_mem = 5'd9; alu_result_mem = 32'h0000_5678;
      #1;
      chk("stall_ready", 64'(mem_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid", 64'(wb_valid), 64'd1);
         chk("stall_rd", 64'(rd_addr_wb), 64'd5);
         chk("stall_wdata", 64'(rd_wdata_wb), 64'h1234);
         chk("stall_we", 64'(regs_write_wb), 64'd1);
         chk("stall_cnt", 64'(retired_cnt), 64'd4);
      end
      wb_stall = 1'b0; flush = 1'b1;
      tick();
      chk("flush_cnt", 64'(retired_cnt), 64'd5);
      chk("flush_valid", 64'(wb_valid), 64'd0);
      chk("flush_we", 64'(regs_write_wb), 64'd0);
      flush = 1'b0;

      // Misaligned LW
      mem_to_reg_mem = 1'b1; funct3_mem = 3'b010; byte_off_mem = 2'd2;
      rd_addr_mem = 5'd3; ram_out_mem = 32'hDEAD_BEEF;
      tick();
      chk("mis_flag", 64'(misaligned_wb), 64'd1);
      chk("mis_we", 64'(regs_write_wb), 64'd0);
      chk("mis_ill", 64'(illegal_ld_wb), 64'd0);
      chk("mis_cnt", 64'(retired_cnt), 64'd5);

      // Reserved funct3
      funct3_mem = 3'b011; byte_off_mem = 2'd0;
      tick();
      chk("ill_flag", 64'(illegal_ld_wb), 64'd1);
      chk("ill_we", 64'(regs_write_wb), 64'd0);
      chk("ill_mis", 64'(misaligned_wb), 64'd0);
      chk("ill_wdata", 64'(rd_wdata_wb), 64'hDEAD_BEEF);
      chk("ill_cnt", 64'(retired_cnt), 64'd6);

      // Write to x0
      mem_to_reg_mem = 1'b0; funct3_mem = 3'b010; rd_addr_mem = 5'd0;
      alu_result_mem = 32'h0000_CAFE;
      tick();
      chk("x0_we", 64'(regs_write_wb), 64'd0);
      chk("x0_fwd", 64'(fwd_en), 64'd0);
      chk("x0_wdata", 64'(rd_wdata_wb), 64'hCAFE);
      chk("x0_cnt", 64'(retired_cnt), 64'd7);

      // Invalid slot with misaligned load bits: flags stay clear
      mem_valid = 1'b0; mem_to_reg_mem = 1'b1; byte_off_mem = 2'd2; rd_addr_mem = 5'd6;
      tick();
      chk("bubble_valid", 64'(wb_valid), 64'd0);
      chk("bubble_mis", 64'(misaligned_wb), 64'd0);
      chk("bubble_cnt", 64'(retired_cnt), 64'd8);

      // Reset while stalled
      mem_valid = 1'b1; wb_stall = 1'b1; rst = 1'b1;
      tick();
      chk("rst_stall_cnt", 64'(retired_cnt), 64'd0);
      chk("rst_stall_wdata", 64'(rd_wdata_wb), 64'd0);
      chk("rst_stall_ready", 64'(mem_ready), 64'd0);
      rst = 1'b0; wb_stall = 1'b0;
      #1;
      chk("unstall_ready", 64'(mem_ready), 64'd1);

      // Counter wrap: 17 back-to-back instructions
      mem_to_reg_mem = 1'b0; rd_addr_mem = 5'd8;
      for (int i = 1; i <= 17; i++) begin
         tick();
         if (i == 16) chk("wrap16_cnt4", 64'(retired_cnt4), 64'd15);
         if (i == 17) chk("wrap17_cnt4", 64'(retired_cnt4), 64'd0);
      end
      mem_valid = 1'b0;
      tick();
      chk("wrap_cnt4", 64'(retired_cnt4), 64'd1);
      chk("wrap_cnt32", 64'(retired_cnt), 64'd17);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
